// File: rtl/sram_layer1_weight_reader_pkg.sv
// Shared constants and state encoding for the layer-1 weight SRAM set.
// The future write-side loader imports this package as well.
package sram_layer1_weight_reader_pkg;

  localparam int BIT_WIDTH_SRAM    = 160;
  localparam int DEPTH_SRAM        = 980;
  localparam int BIT_WIDTH_ADDRESS = 10;
  localparam int SET_NUM           = 10;
  localparam int BIT_WIDTH_LEN     = 10;

  localparam int ROW_WIDTH  = BIT_WIDTH_SRAM * SET_NUM;
  localparam int ADDR_LANES = BIT_WIDTH_ADDRESS * SET_NUM;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sram_seq_state_e;

  // Row address after `a`, wrapping from the last row back to row 0.
  function automatic logic [BIT_WIDTH_ADDRESS-1:0] next_row(input logic [BIT_WIDTH_ADDRESS-1:0] a);
    return (a == BIT_WIDTH_ADDRESS'(DEPTH_SRAM - 1)) ? '0 : a + BIT_WIDTH_ADDRESS'(1);
  endfunction

endpackage

// File: rtl/sram_reader_fifo2.sv
// Two-entry FIFO with occupancy output. Head is combinational from storage,
// so it stays stable while the entry is not popped. Push and pop may coincide,
// including on a full FIFO (the popped slot is the one refilled).
module sram_reader_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;

  // Pointer and occupancy bookkeeping; cleared on reset so buffered rows are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Row storage; no reset needed since occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // The upstream credit rule must never let a row be pushed into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && (occ_q == 2'd2)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && (occ_q == 2'd0)));

endmodule

// File: rtl/sram_layer1_weight_reader.sv
// Read-side initiator for the layer-1 weight SRAM set. Reads a contiguous run
// of rows from all sets in parallel, absorbs the 1-cycle SRAM latency and
// streams rows on valid/ready. Never writes the SRAM.
// Optional build macro READER_SET_MASK_EN adds set_mask_i (1 = set enabled),
// latched at start; disabled sets get no enable, address 0 and a zero lane.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start_i; latches address, length (and mask)
// ST_RUN  | issuing reads under a 2-row credit and draining the FIFO
// ST_DONE | one-cycle done_o pulse, start_i ignored, back to ST_IDLE
module sram_layer1_weight_reader
  import sram_layer1_weight_reader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_i,
  input  logic [BIT_WIDTH_ADDRESS-1:0] start_addr_i,
  input  logic [BIT_WIDTH_LEN-1:0]     length_i,
`ifdef READER_SET_MASK_EN
  input  logic [SET_NUM-1:0]           set_mask_i,
`endif
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ADDR_LANES-1:0]        port1_address_o,
  output logic [SET_NUM-1:0]           port1_enable_o,
  output logic [SET_NUM-1:0]           port1_write_enable_o,
  output logic [ROW_WIDTH-1:0]         port1_write_data_o,
  input  logic [ROW_WIDTH-1:0]         port1_read_data_i,
  output logic [ROW_WIDTH-1:0]         data_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  sram_seq_state_e              state_q;
  logic [BIT_WIDTH_ADDRESS-1:0] addr_q;
  logic [BIT_WIDTH_ADDRESS-1:0] addr_d;
  logic [BIT_WIDTH_LEN-1:0]     remaining_q;
  logic                         inflight_q;
  logic                         busy_q;
  logic                         done_q;
  logic [SET_NUM-1:0]           mask_q;
  logic [SET_NUM-1:0]           mask_in;
  logic [1:0]                   occ;
  logic [ROW_WIDTH-1:0]         fifo_head;
  logic                         pop;
  logic                         issue;
  logic                         last_pop;

`ifdef READER_SET_MASK_EN
  assign mask_in = set_mask_i;
`else
  assign mask_in = '1;
`endif

  assign valid_o = (occ != 2'd0);
  // Pop is combinational from ready_i so a held-high ready sustains one row per cycle.
  assign pop     = valid_o & ready_i;
  // Credit: rows buffered plus the one in flight, minus the one leaving now, must stay below 2.
  assign issue   = (state_q == ST_RUN) && (remaining_q != '0) &&
                   (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign last_pop = (remaining_q == '0) && !inflight_q && (occ == 2'd1) && pop;
  assign addr_d   = next_row(addr_q);

  // Sequencer: start capture, read issue bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= '0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q      <= (start_addr_i >= BIT_WIDTH_ADDRESS'(DEPTH_SRAM)) ? '0 : start_addr_i;
            remaining_q <= length_i;
            mask_q      <= mask_in;
            if (length_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_q - BIT_WIDTH_LEN'(1);
          end
          if (last_pop) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  // Per-set read port drive; lanes carry an address only while being read.
  always_comb begin
    port1_enable_o  = '0;
    port1_address_o = '0;
    for (int i = 0; i < SET_NUM; i++) begin
      if (issue && mask_q[i]) begin
        port1_enable_o[i]                                        = 1'b1;
        port1_address_o[i*BIT_WIDTH_ADDRESS +: BIT_WIDTH_ADDRESS] = addr_q;
      end
    end
  end

  assign port1_write_enable_o = '0;
  assign port1_write_data_o   = '0;

  sram_reader_fifo2 #(
    .WIDTH (ROW_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (inflight_q),
    .wdata_i (port1_read_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .occ_o   (occ)
  );

  // Output row: head of FIFO, zero when empty and for disabled sets.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < SET_NUM; i++) begin
      if (valid_o && mask_q[i]) data_o[i*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM] = fifo_head[i*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM];
    end
  end

endmodule

// File: tb/tb_sram_layer1_weight_reader.sv
// Bench for sram_layer1_weight_reader: behavioural SRAM with 1-cycle latency,
// expected addresses/rows queued at start and compared as the DUT emits them.
module tb_sram_layer1_weight_reader;
  import sram_layer1_weight_reader_pkg::*;

  logic                         clk;
  logic                         reset_n;
  logic                         start_i;
  logic [BIT_WIDTH_ADDRESS-1:0] start_addr_i;
  logic [BIT_WIDTH_LEN-1:0]     length_i;
  logic                         busy_o;
  logic                         done_o;
  logic [ADDR_LANES-1:0]        port1_address_o;
  logic [SET_NUM-1:0]           port1_enable_o;
  logic [SET_NUM-1:0]           port1_write_enable_o;
  logic [ROW_WIDTH-1:0]         port1_write_data_o;
  logic [ROW_WIDTH-1:0]         port1_read_data_i;
  logic [ROW_WIDTH-1:0]         data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic [SET_NUM-1:0]           set_mask;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int exp_addr_q[$];
  int exp_row_q[$];
  logic [SET_NUM-1:0] exp_mask;
  int first_en, first_valid, done_cyc, done_cnt, issued, popped;
  bit busy_seen;
  logic prev_valid, prev_ready;
  logic [ROW_WIDTH-1:0] prev_data;

  sram_layer1_weight_reader dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start_i              (start_i),
    .start_addr_i         (start_addr_i),
    .length_i             (length_i),
`ifdef READER_SET_MASK_EN
    .set_mask_i           (set_mask),
`endif
    .busy_o               (busy_o),
    .done_o               (done_o),
    .port1_address_o      (port1_address_o),
    .port1_enable_o       (port1_enable_o),
    .port1_write_enable_o (port1_write_enable_o),
    .port1_write_data_o   (port1_write_data_o),
    .port1_read_data_i    (port1_read_data_i),
    .data_o               (data_o),
    .valid_o              (valid_o),
    .ready_i              (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BIT_WIDTH_SRAM-1:0] pat(input int s, input int r);
    logic [BIT_WIDTH_SRAM-1:0] v;
    for (int k = 0; k < BIT_WIDTH_SRAM / 32; k++) v[k*32 +: 32] = {8'(s), 8'(k), 16'(r)} ^ 32'h6D2B_79F5;
    return v;
  endfunction

  function automatic logic [ADDR_LANES-1:0] addr_vec(input int a, input logic [SET_NUM-1:0] m);
    logic [ADDR_LANES-1:0] v;
    v = '0;
    for (int i = 0; i < SET_NUM; i++) if (m[i]) v[i*BIT_WIDTH_ADDRESS +: BIT_WIDTH_ADDRESS] = BIT_WIDTH_ADDRESS'(a);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural SRAM: Q is valid the cycle after enable.
  always @(posedge clk) begin
    for (int i = 0; i < SET_NUM; i++)
      if (port1_enable_o[i])
        port1_read_data_i[i*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM] <= pat(i, int'(port1_address_o[i*BIT_WIDTH_ADDRESS +: BIT_WIDTH_ADDRESS]));
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy_o) busy_seen = 1'b1;
      if (valid_o && first_valid < 0) first_valid = cyc;
      if (valid_o && ready_i) begin
        popped++;
        if (exp_row_q.size() == 0) chk("spurious_row", 1, 0);
        else begin
          int r;
          r = exp_row_q.pop_front();
          for (int i = 0; i < SET_NUM; i++)
            chk($sformatf("data_r%0d_l%0d", r, i), data_o[i*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM],
                exp_mask[i] ? pat(i, r) : '0);
        end
      end
      if (valid_o && prev_valid && !prev_ready) chk("stall_hold", data_o == prev_data, 1);
      if (port1_enable_o != '0) begin
        issued++;
        if (first_en < 0) first_en = cyc;
        if (exp_addr_q.size() == 0) chk("spurious_en", 1, 0);
        else begin
          int a;
          a = exp_addr_q.pop_front();
          chk("en_lanes", port1_enable_o, exp_mask);
          chk($sformatf("addr_%0d", a), port1_address_o, addr_vec(a, exp_mask));
        end
        chk("rows_ahead_le2", (issued - popped) <= 2, 1);
        chk("no_write", {port1_write_enable_o, port1_write_data_o == '0}, {{SET_NUM{1'b0}}, 1'b1});
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_data  = data_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic queue_run(input int sa, input int len);
    int base;
    base = (sa >= DEPTH_SRAM) ? 0 : sa;
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back((base + k) % DEPTH_SRAM);
      exp_row_q.push_back((base + k) % DEPTH_SRAM);
    end
  endtask

  // rmode 0: ready held high; rmode 1: ready pattern 1,0,0,1 repeating.
  task automatic run(input int sa, input int len, input int rmode, output int c0);
    int db, k;
    @(posedge clk); #1;
    c0 = cyc;
    first_en = -1; first_valid = -1; busy_seen = 1'b0;
    issued = 0; popped = 0;
    db = done_cnt;
    queue_run(sa, len);
    start_i = 1'b1; start_addr_i = BIT_WIDTH_ADDRESS'(sa); length_i = BIT_WIDTH_LEN'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0;
    while (done_cnt == db && k < 400) begin
      ready_i = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      @(posedge clk); #1;
      k++;
    end
    ready_i = 1'b1;
    chk($sformatf("done_seen_%0d", sa), done_cnt - db, 1);
    chk($sformatf("rows_left_%0d", sa), exp_row_q.size(), 0);
    chk($sformatf("addrs_left_%0d", sa), exp_addr_q.size(), 0);
    chk($sformatf("idle_after_%0d", sa), {busy_o, valid_o}, 2'b00);
  endtask

  initial begin
    int c0, db;
    reset_n = 1'b0; start_i = 1'b0; start_addr_i = '0; length_i = '0; ready_i = 1'b1;
    set_mask = '1; exp_mask = '1;
    first_en = -1; first_valid = -1; done_cyc = -1; done_cnt = 0; issued = 0; popped = 0;
    busy_seen = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_status", {busy_o, done_o, valid_o}, 3'b000);
    chk("rst_en", port1_enable_o, 0);
    chk("rst_addr", port1_address_o, 0);
    chk("rst_data_zero", data_o == '0, 1);
    chk("rst_no_write", {port1_write_enable_o, port1_write_data_o == '0}, {{SET_NUM{1'b0}}, 1'b1});
    #2 reset_n = 1'b1;

    // 4 rows, ready high: latency and done timing
    run(5, 4, 0, c0);
    chk("lat_first_en", first_en - c0, 1);
    chk("lat_first_valid", first_valid - c0, 3);
    chk("lat_done", done_cyc - c0, 7);

    // wrap-around and out-of-range start
    run(978, 4, 0, c0);
    run(1000, 2, 0, c0);
    // backpressure across the wrap point
    run(970, 14, 1, c0);
    chk("bp_first_valid", first_valid - c0, 3);

    // zero length, start held through the DONE cycle
    @(posedge clk); #1;
    c0 = cyc; first_en = -1; busy_seen = 1'b0; db = done_cnt;
    start_i = 1'b1; start_addr_i = 10'd7; length_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("zl_done_cnt", done_cnt - db, 1);
    chk("zl_done_cyc", done_cyc - c0, 1);
    chk("zl_no_en", first_en == -1, 1);
    chk("zl_busy_low", busy_seen, 0);

    // abort mid-run with a start while busy, then restart
    @(posedge clk); #1;
    issued = 0; popped = 0;
    queue_run(100, 8);
    start_i = 1'b1; start_addr_i = 10'd100; length_i = 10'd8;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    start_i = 1'b1; start_addr_i = 10'd500; length_i = 10'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("abort_busy", busy_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_status", {busy_o, done_o, valid_o}, 3'b000);
    chk("abort_en", port1_enable_o, 0);
    chk("abort_data_zero", data_o == '0, 1);
    exp_addr_q.delete();
    exp_row_q.delete();
    #3 reset_n = 1'b1;
    run(0, 2, 0, c0);
    chk("restart_lat_valid", first_valid - c0, 3);

`ifdef READER_SET_MASK_EN
    set_mask = 10'b1111111110;
    exp_mask = 10'b1111111110;
    run(3, 5, 1, c0);
    set_mask = '1;
    exp_mask = '1;
    run(20, 3, 0, c0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
